// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the run monitor and its dump sequencer.
package run_monitor_pkg;

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    DUMP_RD,
    DUMP_CAP,
    DUMP_OUT,
    DONE
  } state_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam int          WORD_STRIDE = 4;

endpackage

// File: rtl/dump_sequencer.sv
// Walks a window of data memory one word at a time and streams each word out
// over a valid/ready channel once start_i is seen.
module dump_sequencer
  import run_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 20
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  start_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [31:0]           mem_rd_data_i,
  output logic                  dump_valid_o,
  input  logic                  dump_ready_i,
  output logic [ADDR_WIDTH-1:0] dump_addr_o,
  output logic [31:0]           dump_data_o,
  output logic                  dump_last_o,
  output logic                  done_o
);

  localparam int WCNT_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam logic [WCNT_W-1:0]     LAST_WORD = WCNT_W'(DUMP_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(DUMP_BASE);
  localparam logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(WORD_STRIDE);

  // RUN doubles as the idle state until the run controller hands over.
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [WCNT_W-1:0]       word_q, word_d;
  logic [31:0]             data_q, data_d;
  logic [ADDR_WIDTH-1:0]   daddr_q, daddr_d;
  logic                    rd_en_q, valid_q, last_q, done_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    case (state_q)
      RUN:      if (start_i) state_d = DUMP_RD;
      DUMP_RD:  state_d = DUMP_CAP;
      DUMP_CAP: begin
        data_d  = mem_rd_data_i;
        daddr_d = addr_q;
        state_d = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (dump_ready_i) begin
          if (word_q == LAST_WORD) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + STRIDE;
            word_d  = word_q + WCNT_W'(1);
            state_d = DUMP_RD;
          end
        end
      end
      DONE:     state_d = DONE;
      default:  state_d = RUN;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      addr_q  <= BASE_ADDR;
      word_q  <= '0;
      data_q  <= '0;
      daddr_q <= BASE_ADDR;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
      rd_en_q <= (state_d == DUMP_RD);
      valid_q <= (state_d == DUMP_OUT);
      last_q  <= (state_d == DUMP_OUT) && (word_d == LAST_WORD);
      done_q  <= (state_d == DONE);
    end
  end

  assign mem_rd_en_o   = rd_en_q;
  assign mem_rd_addr_o = addr_q;
  assign dump_valid_o  = valid_q;
  assign dump_addr_o   = daddr_q;
  assign dump_data_o   = data_q;
  assign dump_last_o   = last_q;
  assign done_o        = done_q;

endmodule

// File: rtl/run_monitor.sv
// Run-control block: detects the halt fetch, counts run cycles, enforces the
// timeout, drains the pipeline, then hands off to the memory dump sequencer.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter logic [31:0] HALT_INST      = EBREAK_INST,
  parameter int          DRAIN_CYCLES   = 5,
  parameter int          TIMEOUT_CYCLES = 20000,
  parameter int          CNT_WIDTH      = 32,
  parameter int          ADDR_WIDTH     = 11,
  parameter int          DUMP_BASE      = 0,
  parameter int          DUMP_WORDS     = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inst_valid,
  input  logic [31:0]           inst,
  output logic                  core_hold,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [31:0]           mem_rd_data,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [31:0]           dump_data,
  output logic                  dump_last,
  output logic [CNT_WIDTH-1:0]  cycles,
  output logic                  halted,
  output logic                  timed_out,
  output logic                  done
);

  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRN_W-1:0]     DRAIN_LOAD   = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  // After hand-off this FSM parks in DUMP_RD; the sequencer owns the rest.
  state_e               state_q, state_d;
  logic [DRN_W-1:0]     drain_q, drain_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic                 halted_q, halted_d;
  logic                 timed_q, timed_d;
  logic                 hold_q, hold_d;
  logic                 start_dump;
  logic                 halt_hit;

  assign halt_hit = inst_valid && (inst == HALT_INST);

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    cycles_d   = cycles_q;
    halted_d   = halted_q;
    timed_d    = timed_q;
    start_dump = 1'b0;
    case (state_q)
      RUN: begin
        if (halt_hit) begin
          halted_d = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            state_d    = DUMP_RD;
            start_dump = 1'b1;
          end else begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end else if (cycles_q == TIMEOUT_LAST) begin
          timed_d    = 1'b1;
          state_d    = DUMP_RD;
          start_dump = 1'b1;
        end else if (cycles_q != {CNT_WIDTH{1'b1}}) begin
          cycles_d = cycles_q + CNT_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          state_d    = DUMP_RD;
          start_dump = 1'b1;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      default: state_d = state_q;
    endcase
    hold_d = hold_q | start_dump;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      drain_q  <= '0;
      cycles_q <= '0;
      halted_q <= 1'b0;
      timed_q  <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      cycles_q <= cycles_d;
      halted_q <= halted_d;
      timed_q  <= timed_d;
      hold_q   <= hold_d;
    end
  end

  assign core_hold = hold_q;
  assign cycles    = cycles_q;
  assign halted    = halted_q;
  assign timed_out = timed_q;

  dump_sequencer #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DUMP_BASE  (DUMP_BASE),
    .DUMP_WORDS (DUMP_WORDS)
  ) u_dump_sequencer (
    .clk           (clk),
    .rst_ni        (reset),
    .start_i       (start_dump),
    .mem_rd_en_o   (mem_rd_en),
    .mem_rd_addr_o (mem_rd_addr),
    .mem_rd_data_i (mem_rd_data),
    .dump_valid_o  (dump_valid),
    .dump_ready_i  (dump_ready),
    .dump_addr_o   (dump_addr),
    .dump_data_o   (dump_data),
    .dump_last_o   (dump_last),
    .done_o        (done)
  );

endmodule

// File: tb/tb_run_monitor.sv
// Randomized bench for run_monitor: two parameterizations checked against a
// run-timeline and dump-word model derived from the block's behaviour.
module tb_run_monitor;
  import run_monitor_pkg::*;

  localparam int AW     = 11;
  localparam int A_DRN  = 5;
  localparam int A_TO   = 200;
  localparam int A_BASE = 0;
  localparam int A_NW   = 20;
  localparam int B_DRN  = 0;
  localparam int B_TO   = 50;
  localparam int B_BASE = 32'h7F8;
  localparam int B_NW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [2];
  logic          iv    [2];
  logic [31:0]   instw [2];
  logic          rdy   [2];
  logic          core_hold [2];
  logic          rd_en  [2];
  logic          dvalid [2];
  logic          dlast  [2];
  logic          halted [2];
  logic          tmo    [2];
  logic          done   [2];
  logic [AW-1:0] rd_addr [2];
  logic [AW-1:0] daddr   [2];
  logic [31:0]   rdata [2];
  logic [31:0]   ddata [2];
  logic [31:0]   cyc   [2];
  int unsigned   seed  [2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [AW-1:0] a, input int unsigned sd);
    return sd ^ (32'(a) * 32'h9E37_79B1) ^ {21'd0, a};
  endfunction

  // Synchronous-read memory model: data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en[0]) rdata[0] <= memf(rd_addr[0], seed[0]);
    if (rd_en[1]) rdata[1] <= memf(rd_addr[1], seed[1]);
  end

  run_monitor #(
    .DRAIN_CYCLES(A_DRN), .TIMEOUT_CYCLES(A_TO), .CNT_WIDTH(32),
    .ADDR_WIDTH(AW), .DUMP_BASE(A_BASE), .DUMP_WORDS(A_NW)
  ) u_a (
    .clk(clk), .reset(rst_n[0]), .inst_valid(iv[0]), .inst(instw[0]),
    .core_hold(core_hold[0]), .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]),
    .mem_rd_data(rdata[0]), .dump_valid(dvalid[0]), .dump_ready(rdy[0]),
    .dump_addr(daddr[0]), .dump_data(ddata[0]), .dump_last(dlast[0]),
    .cycles(cyc[0]), .halted(halted[0]), .timed_out(tmo[0]), .done(done[0])
  );

  run_monitor #(
    .DRAIN_CYCLES(B_DRN), .TIMEOUT_CYCLES(B_TO), .CNT_WIDTH(32),
    .ADDR_WIDTH(AW), .DUMP_BASE(B_BASE), .DUMP_WORDS(B_NW)
  ) u_b (
    .clk(clk), .reset(rst_n[1]), .inst_valid(iv[1]), .inst(instw[1]),
    .core_hold(core_hold[1]), .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]),
    .mem_rd_data(rdata[1]), .dump_valid(dvalid[1]), .dump_ready(rdy[1]),
    .dump_addr(daddr[1]), .dump_data(ddata[1]), .dump_last(dlast[1]),
    .cycles(cyc[1]), .halted(halted[1]), .timed_out(tmo[1]), .done(done[1])
  );

  task automatic chk_reset(input int s, input string tag);
    logic [AW-1:0] base;
    base = AW'((s == 0) ? A_BASE : B_BASE);
    chk({tag, "_hold"},   core_hold[s], 0);
    chk({tag, "_rden"},   rd_en[s],     0);
    chk({tag, "_valid"},  dvalid[s],    0);
    chk({tag, "_last"},   dlast[s],     0);
    chk({tag, "_halted"}, halted[s],    0);
    chk({tag, "_tmo"},    tmo[s],       0);
    chk({tag, "_done"},   done[s],      0);
    chk({tag, "_cycles"}, cyc[s],       0);
    chk({tag, "_ddata"},  ddata[s],     0);
    chk({tag, "_rdaddr"}, rd_addr[s],   base);
    chk({tag, "_daddr"},  daddr[s],     base);
  endtask

  // h < 0: no halt. stall_w: word held off for 7 cycles. rst_w: word during
  // whose output phase reset is asserted. rnd: random dump_ready.
  task automatic run_case(input int s, input int h, input int stall_w,
                          input int rst_w, input bit rnd);
    int drn, to, base, nw, stop, first;
    bit halt_eff;
    int hcyc, frst, dcyc, rdc, nacc, stn;
    bit prev_hold;
    logic [AW-1:0] h_addr, ea;
    logic [31:0]   h_data;
    logic [AW-1:0] qa[$];
    logic [31:0]   qd[$];
    bit            ql[$];

    drn  = (s == 0) ? A_DRN  : B_DRN;
    to   = (s == 0) ? A_TO   : B_TO;
    base = (s == 0) ? A_BASE : B_BASE;
    nw   = (s == 0) ? A_NW   : B_NW;
    halt_eff = (h >= 0) && (h <= to - 1);
    stop  = halt_eff ? h : to - 1;
    first = halt_eff ? h + 1 + drn : to;
    hcyc = -1; frst = -1; dcyc = -1; rdc = 0; nacc = 0; stn = 0;
    prev_hold = 1'b0; h_addr = '0; h_data = '0;

    seed[s] = $urandom;
    @(negedge clk);
    rst_n[s] = 1'b0; iv[s] = 1'b0; instw[s] = '0; rdy[s] = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset(s, "rst");
    rst_n[s] = 1'b1;

    for (int k = 0; k < 2000; k++) begin
      if (halted[s] && hcyc < 0) hcyc = k;
      if (rd_en[s]) begin
        rdc++;
        if (frst < 0) begin
          frst = k;
          chk("hold_at_first_rd", core_hold[s], 1);
          chk("hold_before_rd", prev_hold, 0);
        end
      end
      prev_hold = core_hold[s];
      if (done[s]) begin
        dcyc = k;
        break;
      end
      if (dvalid[s]) begin
        if (nacc == rst_w) begin
          rdy[s] = 1'b0;
          rst_n[s] = 1'b0;
          #1;
          chk_reset(s, "midrst");
          repeat (2) @(negedge clk);
          rst_n[s] = 1'b1; iv[s] = 1'b0;
          chk("rerun_cyc0", cyc[s], 0);
          @(negedge clk);
          chk("rerun_cyc1", cyc[s], 1);
          chk("rerun_hold", core_hold[s], 0);
          @(negedge clk);
          chk("rerun_cyc2", cyc[s], 2);
          chk("rerun_halted", halted[s], 0);
          return;
        end
        if (nacc == stall_w && stn < 7) begin
          if (stn == 0) begin
            h_addr = daddr[s]; h_data = ddata[s];
            chk("stall_word_addr", h_addr, AW'(base + 4 * stall_w));
          end else begin
            chk("stall_addr_hold", daddr[s], h_addr);
            chk("stall_data_hold", ddata[s], h_data);
          end
          chk("stall_no_rd", rd_en[s], 0);
          rdy[s] = 1'b0;
          stn++;
        end else begin
          rdy[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (rdy[s]) begin
          if (nacc == stall_w) begin
            chk("stall_addr_accept", daddr[s], h_addr);
            chk("stall_data_accept", ddata[s], h_data);
          end
          qa.push_back(daddr[s]); qd.push_back(ddata[s]); ql.push_back(dlast[s]);
          nacc++;
        end
      end else begin
        rdy[s] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (k == h) begin
        iv[s] = 1'b1; instw[s] = EBREAK_INST;
      end else if (h >= 0 && k > h) begin
        iv[s] = 1'($urandom_range(0, 1)); instw[s] = EBREAK_INST;
      end else begin
        iv[s] = 1'($urandom_range(0, 1)); instw[s] = $urandom;
        if (instw[s] == EBREAK_INST) instw[s] = instw[s] ^ 32'd1;
      end
      @(negedge clk);
    end

    chk("done_reached", dcyc >= 0, 1);
    chk("cycles_final", cyc[s], stop);
    chk("halted_final", halted[s], halt_eff);
    chk("timed_out_final", tmo[s], !halt_eff);
    chk("halted_rise_cycle", hcyc, halt_eff ? h + 1 : -1);
    chk("first_rd_cycle", frst, first);
    chk("rd_count", rdc, nw);
    chk("word_count", nacc, nw);
    for (int i = 0; i < qa.size(); i++) begin
      ea = AW'(base + 4 * i);
      chk($sformatf("w%0d_addr", i), qa[i], ea);
      chk($sformatf("w%0d_data", i), qd[i], memf(ea, seed[s]));
      chk($sformatf("w%0d_last", i), ql[i], i == nw - 1);
    end
    chk("done_hold", core_hold[s], 1);
    chk("done_rden", rd_en[s], 0);
    chk("done_valid", dvalid[s], 0);
    chk("done_last", dlast[s], 0);
    if (!rnd && stall_w < 0) chk("dump_duration", dcyc - frst, 3 * nw);
    @(negedge clk);
    chk("done_sticky", done[s], 1);
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; iv[s] = 1'b0; instw[s] = '0; rdy[s] = 1'b0; seed[s] = 0;
    end
    run_case(0, 99, -1, -1, 1'b0);
    run_case(0, 99, 3, -1, 1'b0);
    run_case(0, A_TO - 1, -1, -1, 1'b1);
    run_case(0, 30, -1, 5, 1'b0);
    run_case(0, int'($urandom_range(0, 150)), -1, -1, 1'b1);
    run_case(1, -1, -1, -1, 1'b0);
    run_case(1, 10, -1, -1, 1'b1);
    run_case(1, B_TO - 1, 2, -1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run-control and result-extraction block for the no-io SoC flow. It watches the processor's instruction-fetch stream for a configurable halt instruction, counts run cycles, and enforces a timeout. After the halt it drains the pipeline for a parameterised number of cycles, holds the core, then walks a window of data memory through a read port and streams each word out over a valid/ready channel. It sits beside the SoC core, between the fetch bus, a DMEM read port, and the host/bench capture logic.

## Interface
- `HALT_INST`, 32'h0010_0073, instruction word that ends the run (ebreak).
- `DRAIN_CYCLES`, 5, cycles between halt detection and `core_hold`; 0 allowed.
- `TIMEOUT_CYCLES`, 20000, run cycles before a forced stop; must be ≥1.
- `CNT_WIDTH`, 32, width of the cycle counter.
- `ADDR_WIDTH`, 11, DMEM byte-address width.
- `DUMP_BASE`, 0, first byte address dumped; word aligned.
- `DUMP_WORDS`, 20, number of 32-bit words dumped; ≥1.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `inst_valid`  in  1  fetch word on `inst` is valid this cycle.
- `inst`  in  32  fetched instruction.
- `core_hold`  out  1  freezes the core; high from end of drain until reset.
- `mem_rd_en`  out  1  DMEM read strobe.
- `mem_rd_addr`  out  ADDR_WIDTH  byte address, word aligned.
- `mem_rd_data`  in  32  read data, valid exactly 1 cycle after `mem_rd_en`.
- `dump_valid`  out  1  dump word available.
- `dump_ready`  in  1  consumer accepts word.
- `dump_addr`  out  ADDR_WIDTH  byte address of `dump_data`.
- `dump_data`  out  32  memory word.
- `dump_last`  out  1  qualifies final word.
- `cycles`  out  CNT_WIDTH  run-cycle count.
- `halted`  out  1  halt instruction seen (sticky).
- `timed_out`  out  1  timeout fired (sticky).
- `done`  out  1  dump complete (sticky).

## Operation
- States: RUN, DRAIN, DUMP_RD, DUMP_CAP, DUMP_OUT, DONE. Reset → RUN.
- RUN: `cycles` increments every cycle, saturating at all-ones. `inst_valid && inst==HALT_INST` → set `halted`, freeze `cycles`, go to DRAIN (or DUMP_RD if `DRAIN_CYCLES`==0).
- Timeout: in RUN, when `cycles`==TIMEOUT_CYCLES−1 with no halt this cycle → set `timed_out`, freeze `cycles`, go directly to DUMP_RD (no drain). Halt and timeout in the same cycle: halt wins, `timed_out` stays 0.
- DRAIN: down-counter loaded with DRAIN_CYCLES; `inst` ignored; at zero → DUMP_RD.
- `core_hold` asserts on entry to DUMP_RD and stays high through DONE.
- DUMP_RD: one-cycle `mem_rd_en` at current address → DUMP_CAP.
- DUMP_CAP: register `mem_rd_data` into `dump_data` and the address into `dump_addr` → DUMP_OUT.
- DUMP_OUT: `dump_valid` high; `dump_data`/`dump_addr`/`dump_last` stable until `dump_ready`. On handshake: if last → DONE, else address += 4 → DUMP_RD.
- Address wraps modulo 2^ADDR_WIDTH; no error raised.
- DONE: `done`=1; all strobes low; terminal until reset.
- Reset mid-operation (any state, including during a pending handshake): immediate return to RUN with all outputs at reset values; the partial dump is discarded.

## Timing
- Reset values: `core_hold`, `mem_rd_en`, `dump_valid`, `dump_last`, `halted`, `timed_out`, `done` = 0; `cycles`, `dump_data` = 0; `mem_rd_addr`, `dump_addr` = DUMP_BASE.
- `cycles` = number of RUN cycles strictly before the halt-fetch cycle; the first cycle after reset release counts as 0.
- Halt fetch at cycle T: `halted` high at T+1; first `mem_rd_en` at T+1+DRAIN_CYCLES.
- Per word: minimum 3 cycles (RD, CAP, OUT with `dump_ready` already high); `dump_ready` may be held high continuously.
- Outputs are registered; no combinational path from `dump_ready` to `dump_valid`.

## Structure
- Shared package `run_monitor_pkg`: state enum, default HALT_INST (ebreak) constant, word-stride constant (4).
- Natural sub-module: `dump_sequencer` (DUMP_RD/CAP/OUT states, address counter, word counter, valid/ready); `run_monitor` owns RUN/DRAIN, cycle counter, timeout, and status flags.

## Test plan
- Halt at 100th post-reset cycle, DRAIN_CYCLES=5, `dump_ready`=1 → `cycles`=99, first `mem_rd_en` 6 cycles after halt fetch, 20 words at addresses 0..76, `dump_last` on address 76, `done`=1.
- No halt, TIMEOUT_CYCLES=50 → `timed_out`=1, `halted`=0, `cycles`=49, dump starts the next cycle without drain.
- Halt coincident with timeout cycle → `halted`=1, `timed_out`=0.
- `dump_ready` low 7 cycles on word 3 → `dump_valid`, `dump_data`, `dump_addr`=12 held stable; no extra `mem_rd_en` issued.
- DUMP_BASE=0x7F8, ADDR_WIDTH=11, DUMP_WORDS=4 → addresses 0x7F8, 0x7FC, 0x000, 0x004.
- `reset` asserted during DUMP_OUT of word 5 → all outputs at reset values immediately; after release, `cycles` restarts from 0 in RUN.
